// File: rtl/miner_pkg.sv
// miner_pkg: definitions shared by the miner blocks.
//   - Default work-packet geometry (midstate and block-tail byte counts), also used by
//     the hashing core so both sides agree on the packet layout.
//   - State encoding of the UART work assembler.
package miner_pkg;

  localparam int MIDSTATE_BYTES_DEFAULT = 32;
  localparam int DATA_BYTES_DEFAULT     = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    DRAIN   = 2'd3
  } asmState_t;

endpackage

// File: rtl/uart_work_assembler.sv
// uart_work_assembler
//   Collects bytes from the RS-232 byte receiver into one fixed-length work packet
//   (SHA-256 midstate followed by block-tail data). A packet is delimited by the
//   receiver's end-of-packet pulse. Complete packets are presented to the hashing core
//   with a one-cycle work_valid strobe; short, over-long and (optionally) bad-checksum
//   packets are dropped and flagged with a one-cycle error strobe.
//
//   Build option WORK_CHECKSUM_EN: when defined, every packet carries one extra trailing
//   byte equal to the XOR of all preceding bytes; the packet is accepted only when that
//   byte matches. When undefined, the packet is accepted on its last data byte and
//   err_chk is tied to 0.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   rx_valid   in   one-cycle strobe, rx_data holds a received byte
//   rx_data    in   received byte [7:0]
//   rx_eop     in   one-cycle strobe, line went idle after a burst
//   work_valid out  one-cycle strobe, midstate/data hold a new packet
//   midstate   out  midstate [MIDSTATE_BYTES*8-1:0], first received byte in the MSBs
//   data       out  tail data [DATA_BYTES*8-1:0], last packet byte in [7:0]
//   err_len    out  one-cycle strobe, packet dropped for wrong length
//   err_chk    out  one-cycle strobe, packet dropped for checksum mismatch
//   pkt_count  out  accepted packet count [7:0], wraps 255->0
module uart_work_assembler
  import miner_pkg::*;
#(
  parameter int MIDSTATE_BYTES = miner_pkg::MIDSTATE_BYTES_DEFAULT,
  parameter int DATA_BYTES     = miner_pkg::DATA_BYTES_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_eop,
  output logic                        work_valid,
  output logic [MIDSTATE_BYTES*8-1:0] midstate,
  output logic [DATA_BYTES*8-1:0]     data,
  output logic                        err_len,
  output logic                        err_chk,
  output logic [7:0]                  pkt_count
);

  localparam int PKT_BYTES = MIDSTATE_BYTES + DATA_BYTES;
  localparam int PKT_BITS  = PKT_BYTES * 8;
  localparam int MS_BITS   = MIDSTATE_BYTES * 8;
  localparam int DATA_BITS = DATA_BYTES * 8;
  // Room for PKT_BYTES plus the checksum byte and one more.
  localparam int CNT_W     = $clog2(PKT_BYTES + 3);
  localparam logic [CNT_W-1:0] PKT_CNT = CNT_W'(PKT_BYTES);

  asmState_t            state, stateNext;
  logic [CNT_W-1:0]     count, countNext, countInc;
  logic [PKT_BITS-1:0]  shiftBuf, bufNext;
  logic                 accept;
  logic                 lenErr;
`ifdef WORK_CHECKSUM_EN
  logic [7:0]           xorAcc, xorNext;
  logic                 chkErr;
`endif

  assign countInc = count + 1'b1;

  always_comb begin
    stateNext = state;
    countNext = count;
    bufNext   = shiftBuf;
    accept    = 1'b0;
    lenErr    = 1'b0;
`ifdef WORK_CHECKSUM_EN
    xorNext   = xorAcc;
    chkErr    = 1'b0;
`endif

    // Byte handling first; rx_eop is judged afterwards on the updated state.
    case (state)
      IDLE, COLLECT: begin
        if (rx_valid) begin
          countNext = countInc;
          bufNext   = {shiftBuf[PKT_BITS-9:0], rx_data};
`ifdef WORK_CHECKSUM_EN
          xorNext   = xorAcc ^ rx_data;
`endif
          if (countInc == PKT_CNT) begin
`ifdef WORK_CHECKSUM_EN
            stateNext = FULL;
`else
            // FULL is transient here: the packet is taken in the same cycle.
            accept    = 1'b1;
            countNext = '0;
            stateNext = IDLE;
`endif
          end else if (countInc > PKT_CNT) begin
            stateNext = DRAIN;
          end else begin
            stateNext = COLLECT;
          end
        end
      end
      FULL: begin
        if (rx_valid) begin
`ifdef WORK_CHECKSUM_EN
          if (rx_data == xorAcc) accept = 1'b1;
          else                   chkErr = 1'b1;
          countNext = '0;
          stateNext = IDLE;
`else
          stateNext = DRAIN;
`endif
        end
      end
      DRAIN: begin
        // Over-long packet: bytes are discarded until the line goes idle.
      end
      default: stateNext = IDLE;
    endcase

    // End of packet while a packet is still open means the length was wrong.
    if (rx_eop && (stateNext != IDLE)) begin
      lenErr    = 1'b1;
      countNext = '0;
      stateNext = IDLE;
    end

`ifdef WORK_CHECKSUM_EN
    if (stateNext == IDLE) xorNext = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      shiftBuf   <= '0;
      midstate   <= '0;
      data       <= '0;
      work_valid <= 1'b0;
      err_len    <= 1'b0;
      pkt_count  <= '0;
    end else begin
      state      <= stateNext;
      count      <= countNext;
      shiftBuf   <= bufNext;
      work_valid <= accept;
      err_len    <= lenErr;
      if (accept) begin
        // bufNext already contains the final data byte when there is no checksum.
        midstate  <= bufNext[PKT_BITS-1 -: MS_BITS];
        data      <= bufNext[DATA_BITS-1:0];
        pkt_count <= pkt_count + 8'd1;
      end
    end
  end

`ifdef WORK_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xorAcc  <= '0;
      err_chk <= 1'b0;
    end else begin
      xorAcc  <= xorNext;
      err_chk <= chkErr;
    end
  end
`else
  assign err_chk = 1'b0;
`endif

endmodule
